// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers.
// The result is computed at launch and held pending until the busy countdown expires.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic          pwe_q, pwe_d;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   a_mag, b_mag, b_nz, b_mag_nz, uq, ur, sq, sr, dq, dr;
   logic          launch;
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'b0, a} * {32'b0, b};
   // Signed division through magnitudes so 0x80000000 / -1 wraps cleanly.
   assign a_mag    = a[31] ? -a : a;
   assign b_mag    = b[31] ? -b : b;
   assign b_nz     = (b == 32'd0) ? 32'd1 : b;
   assign b_mag_nz = (b == 32'd0) ? 32'd1 : b_mag;
   assign uq = a_mag / b_mag_nz;
   assign ur = a_mag % b_mag_nz;
   assign sq = (a[31] ^ b[31]) ? -uq : uq;
   assign sr = a[31] ? -ur : ur;
   assign dq = op[0] ? a / b_nz : sq;
   assign dr = op[0] ? a % b_nz : sr;
   assign launch = start && state_q == IDLE && !op[2];
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      pwe_d   = pwe_q;
      if (state_q == RUN) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            hi_d    = pwe_q ? phi_q : hi_q;
            lo_d    = pwe_q ? plo_q : lo_q;
         end
      end else if (launch) begin
         state_d = RUN;
         cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         phi_d   = op[1] ? dr : (op[0] ? prod_u[63:32] : prod_s[63:32]);
         plo_d   = op[1] ? dq : (op[0] ? prod_u[31:0] : prod_s[31:0]);
         pwe_d   = !(op[1] && b == 32'd0);
      end else if (start && op == 3'd4) begin
         hi_d = a;
      end else if (start && op == 3'd5) begin
         lo_d = a;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         pwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         pwe_q   <= pwe_d;
      end
   end
   assign busy = state_q == RUN;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit with HI/LO registers for the MIPS datapath.
- Sits directly downstream of the general register file: consumes rs/rt read data as operands.
- Feeds HI/LO back toward register write-back for mfhi/mflo.
- Models multi-cycle latency with a busy flag that the stall controller uses to hold dependent md instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch op for one cycle; sampled on rising edge
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved (no-op)
- a  input  32  operand A (rs read data)
- b  input  32  operand B (rt read data)
- busy  output  1  high while a mult/div is in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset is synchronous and active-high on clock clk:
  - hi=0, lo=0, busy=0, cycle counter=0, pending result cleared.
  - Reset mid-operation aborts the op; no HI/LO update follows.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE + start + op in {0..3}, at edge T:
  - Capture a, b and op.
  - Compute the result into internal pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high from after edge T.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter reaches 0, commit pending to hi/lo and return to IDLE; busy falls at that edge.
  - For an op launched at edge T, busy is high for exactly N cycles (N = parameter), and hi/lo show the new value after edge T+N.
- hi/lo hold their old value throughout RUN; no partial results are ever visible.
- mthi/mtlo (op 4/5) with start in IDLE:
  - Single-cycle write of a into hi or lo at that edge.
  - busy stays 0.
- start while busy=1: ignored entirely. The stall controller guarantees this never happens; do not queue.
- start with op 6/7: no effect.
- Arithmetic:
  - mult: {hi,lo} = signed(a) * signed(b), full 64-bit product.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with sign of dividend.
  - divu: unsigned lo = a/b, hi = a%b.
- Boundary conditions:
  - div/divu with b=0: still busy for DIV_CYCLES, but hi/lo stay unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Operands are latched at launch, so changes on a/b during RUN have no effect.
- Reset asserted in the same cycle as start: reset wins; op not launched.
- Back-to-back: start accepted in the cycle busy falls (IDLE at that edge) → new op launches at the next edge. A new start coincident with the commit edge is not accepted, because the block is still in RUN.

Test Plan:
- Reset → hi=0, lo=0, busy=0.
- mult a=0xFFFFFFFE(-2), b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div a=-7 (0xFFFFFFF9), b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=2 → lo=3, hi=1.
- div by zero with hi=0x11, lo=0x22 preset via mthi/mtlo → busy 10 cycles, then hi=0x11, lo=0x22.
- mthi a=0x12345678 → hi updated next edge, busy stays 0.
- start mult during RUN → ignored.
- reset asserted 3 cycles into a div → busy=0, hi=lo=0, and no later commit.
